// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot-image loader.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_loader_rise_detect.sv
// Rising-edge detector on the UART ready flag; a held level yields one event.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise_c
);

  logic sig_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sig_q <= 1'b0;
    else        sig_q <= sig;
  end

  assign rise_c = sig & ~sig_q;

endmodule

// File: rtl/uart_loader.sv
// Parses a framed boot image from the UART, writes words into instruction
// memory, and holds the CPU in reset until a load completes with a good checksum.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 2,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_ready,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_wdata,
  output logic                    cpu_hold,
  output logic                    done,
  output logic                    error
);

  localparam int unsigned WORD_W = 8 * WORD_BYTES;
  localparam int unsigned BIDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(WORD_BYTES - 1);

  logic accept_c;

  rise_detect u_rise (
    .clk    (clk),
    .reset  (reset),
    .sig    (rx_ready),
    .rise_c (accept_c)
  );

  state_t              state_q, state_n;
  logic [7:0]          len_q, len_n;
  logic [7:0]          word_cnt_q, word_cnt_n;
  logic [BIDX_W-1:0]   byte_idx_q, byte_idx_n;
  logic [WORD_W-1:0]   asm_q, asm_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [7:0]          csum_q, csum_n;
  logic                mem_we_n, cpu_hold_n, done_n, error_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [WORD_W-1:0]   mem_wdata_n;

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      addr_q     <= '0;
      csum_q     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_n;
      len_q      <= len_n;
      word_cnt_q <= word_cnt_n;
      byte_idx_q <= byte_idx_n;
      asm_q      <= asm_n;
      addr_q     <= addr_n;
      csum_q     <= csum_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      cpu_hold   <= cpu_hold_n;
      done       <= done_n;
      error      <= error_n;
    end
  end

  // Frame parser: next state and next values of every register
  always_comb begin
    state_n     = state_q;
    len_n       = len_q;
    word_cnt_n  = word_cnt_q;
    byte_idx_n  = byte_idx_q;
    asm_n       = asm_q;
    addr_n      = addr_q;
    csum_n      = csum_q;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    cpu_hold_n  = cpu_hold;
    done_n      = done;
    error_n     = error;

    if (accept_c) begin
      unique case (state_q)
        IDLE, DONE: begin
          if (rx_data == SYNC_BYTE) begin
            state_n    = LEN;
            cpu_hold_n = 1'b1;
            done_n     = 1'b0;
            error_n    = 1'b0;
          end
        end
        LEN: begin
          len_n      = rx_data;
          word_cnt_n = '0;
          byte_idx_n = '0;
          addr_n     = '0;
          csum_n     = '0;
          state_n    = DATA;
        end
        DATA: begin
          for (int i = 0; i < int'(WORD_BYTES); i++) begin
            if (byte_idx_q == BIDX_W'(i)) asm_n[8*i +: 8] = rx_data;
          end
          csum_n = csum_q + rx_data;
          if (byte_idx_q == LAST_BYTE) begin
            mem_we_n    = 1'b1;
            mem_addr_n  = addr_q;
            mem_wdata_n = asm_n;
            addr_n      = addr_q + ADDR_W'(1);
            byte_idx_n  = '0;
            if (word_cnt_q == len_q) state_n = CSUM;
            else                     word_cnt_n = word_cnt_q + 8'd1;
          end else begin
            byte_idx_n = byte_idx_q + BIDX_W'(1);
          end
        end
        CSUM: begin
          if (rx_data == csum_q) begin
            state_n    = DONE;
            done_n     = 1'b1;
            cpu_hold_n = 1'b0;
          end else begin
            state_n = IDLE;
            error_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed self-checking bench for uart_loader with a write monitor.
module tb_uart_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold, done, error;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [7:0]  wr_addr_q[$];
  logic [15:0] wr_data_q[$];

  uart_loader #(.WORD_BYTES(2), .ADDR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Each negedge with mem_we high is one write.
  always @(negedge clk) begin
    if (reset && mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    repeat (hold) @(negedge clk);
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic chk_single(input string tag, input logic [7:0] a, input logic [15:0] d);
    chk({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() == 1) begin
      chk({tag, "_addr"}, 32'(wr_addr_q[0]), 32'(a));
      chk({tag, "_data"}, 32'(wr_data_q[0]), 32'(d));
    end
  endtask

  logic [7:0] good_frame[5];
  logic [7:0] bad_frame[5];
  logic [7:0] noise_frame[8];
  logic [7:0] csum;

  initial begin
    good_frame  = '{8'hA5, 8'h00, 8'h34, 8'h12, 8'h46};
    bad_frame   = '{8'hA5, 8'h00, 8'h34, 8'h12, 8'h47};
    noise_frame = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h01, 8'h00, 8'h01};

    reset = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_we",    32'(mem_we),    32'd0);
    chk("rst_addr",  32'(mem_addr),  32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_hold",  32'(cpu_hold),  32'd1);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_err",   32'(error),     32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single good word
    clear_writes();
    foreach (good_frame[i]) send_byte(good_frame[i], 1);
    chk_single("one", 8'h00, 16'h1234);
    chk("one_done", 32'(done),     32'd1);
    chk("one_hold", 32'(cpu_hold), 32'd0);
    chk("one_err",  32'(error),    32'd0);

    // Bad checksum keeps the written word, flags error
    clear_writes();
    foreach (bad_frame[i]) send_byte(bad_frame[i], 1);
    chk_single("bad", 8'h00, 16'h1234);
    chk("bad_err",  32'(error),    32'd1);
    chk("bad_done", 32'(done),     32'd0);
    chk("bad_hold", 32'(cpu_hold), 32'd1);
    chk("bad_state", 32'(dut.state_q), 32'd0);

    // Noise before sync is ignored
    clear_writes();
    foreach (noise_frame[i]) send_byte(noise_frame[i], 1);
    chk_single("noise", 8'h00, 16'h0001);
    chk("noise_done", 32'(done),  32'd1);
    chk("noise_err",  32'(error), 32'd0);

    // Ready held as a level for 20 cycles per byte
    clear_writes();
    foreach (good_frame[i]) send_byte(good_frame[i], 20);
    chk_single("level", 8'h00, 16'h1234);
    chk("level_done", 32'(done),     32'd1);
    chk("level_hold", 32'(cpu_hold), 32'd0);

    // Reset in the middle of a frame
    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    send_byte(8'hAA, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_we",    32'(mem_we),    32'd0);
    chk("mrst_addr",  32'(mem_addr),  32'd0);
    chk("mrst_wdata", 32'(mem_wdata), 32'd0);
    chk("mrst_hold",  32'(cpu_hold),  32'd1);
    chk("mrst_done",  32'(done),      32'd0);
    chk("mrst_err",   32'(error),     32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_state", 32'(dut.state_q), 32'd0);
    clear_writes();
    foreach (good_frame[i]) send_byte(good_frame[i], 1);
    chk_single("mrst", 8'h00, 16'h1234);
    chk("mrst_done2", 32'(done), 32'd1);

    // Full 256-word frame: word i = {0x5A, i}
    clear_writes();
    csum = 8'h00;
    send_byte(8'hA5, 1);
    send_byte(8'hFF, 1);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i), 1);
      send_byte(8'h5A, 1);
      csum = csum + 8'(i) + 8'h5A;
    end
    chk("full_csum_const", 32'(csum), 32'h80);
    send_byte(csum, 1);
    chk("full_nwr", 32'(wr_addr_q.size()), 32'd256);
    for (int i = 0; i < 256 && i < wr_addr_q.size(); i++) begin
      chk($sformatf("full_addr%0d", i), 32'(wr_addr_q[i]), 32'(i));
      chk($sformatf("full_data%0d", i), 32'(wr_data_q[i]), {16'h0, 8'h5A, 8'(i)});
    end
    chk("full_done", 32'(done),     32'd1);
    chk("full_hold", 32'(cpu_hold), 32'd0);

    // Reload: sync byte clears done and raises hold the next cycle
    @(negedge clk);
    rx_data  = 8'hA5;
    rx_ready = 1'b1;
    @(negedge clk);
    chk("reload_done", 32'(done),     32'd0);
    chk("reload_hold", 32'(cpu_hold), 32'd1);
    chk("reload_err",  32'(error),    32'd0);
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
